multi_crack_ctrl: RTL and testbench
===================================

MULTI_CRACK_CTRL -- requirements
Module: multi_crack_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENG, default 2, giving the number of parallel crack engines (1..8).
REQ-002 SHALL have parameter KEY_W, default 24, giving the key width in bits.
REQ-003 SHALL have parameter CNT_W, default 32, giving the search-cycle counter width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 en  in  1  host start request, sampled only while rdy=1.
REQ-008 rdy  out  1  controller idle, able to accept en.
REQ-009 key  out  KEY_W  winning key of last search.
REQ-010 key_valid  out  1  last search found a key.
REQ-011 search_cycles  out  CNT_W  cycles spent in last search.
REQ-012 eng_en  out  NUM_ENG  one-cycle start pulse per engine.
REQ-013 eng_start  out  NUM_ENG*KEY_W  engine i starting key, slice i = i.
REQ-014 eng_stride  out  KEY_W  key increment for all engines, constant NUM_ENG.
REQ-015 eng_rdy  in  NUM_ENG  engine idle/finished.
REQ-016 eng_key  in  NUM_ENG*KEY_W  engine result keys, slice i from engine i.
REQ-017 eng_key_valid  in  NUM_ENG  engine result-valid flags.
REQ-018 eng_abort  out  NUM_ENG  stop request to engines (present only with FOUND_ABORT_EN).

Function
REQ-019 SHALL implement states IDLE, DISPATCH, COLLECT, REPORT.
REQ-020 IDLE: rdy=1; en=1 -> DISPATCH next cycle, rdy=0; clear key_valid, done mask, counter.
REQ-021 DISPATCH: wait until eng_rdy all ones; in that cycle pulse eng_en all ones for exactly one cycle -> COLLECT.
REQ-022 COLLECT: ignore eng_rdy in the first cycle after the pulse; thereafter engine i done on first cycle eng_rdy[i]=1, set done[i].
REQ-023 On done[i] rising with eng_key_valid[i]=1 and no winner latched, latch key=eng_key slice i, key_valid=1.
REQ-024 Multiple engines finishing valid in the same cycle: lowest index wins.
REQ-025 Valid results after a winner is latched SHALL be ignored.
REQ-026 COLLECT -> REPORT when done mask is all ones.
REQ-027 REPORT: hold one cycle, then -> IDLE; rdy=1 from the cycle after REPORT.
REQ-028 search_cycles increments every cycle in DISPATCH and COLLECT, saturates at all ones, and freezes in REPORT/IDLE.
REQ-029 key, key_valid, search_cycles SHALL hold their values in IDLE until next accepted en.
REQ-030 en while rdy=0 SHALL be ignored; no queuing.
REQ-031 eng_start and eng_stride SHALL be constant combinational values derived from parameters.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, rdy=1, key=0, key_valid=0, search_cycles=0, eng_en=0, eng_abort=0, done mask=0.
REQ-033 Reset mid-search SHALL discard the search; no eng_en pulse until a new en is accepted after release.

Configuration
REQ-034 Macro FOUND_ABORT_EN: when defined, eng_abort exists; on the winner-latch cycle, eng_abort asserts for every engine with done[i]=0 and holds until the state leaves COLLECT; aborted engines are still awaited via eng_rdy.
REQ-035 Without FOUND_ABORT_EN, no eng_abort port exists and all engines run to completion.

Verification
REQ-036 NUM_ENG=2, engine 1 finishes valid key 0x000123 at cycle 40, engine 0 finishes invalid at cycle 60 -> key=0x000123, key_valid=1, rdy=1 after REPORT.
REQ-037 Both engines invalid -> key_valid=0, key=0, search_cycles equals cycles from DISPATCH entry to REPORT.
REQ-038 Both engines valid in the same cycle, keys 0x000010/0x000011 -> key=0x000010.
REQ-039 eng_rdy[1]=0 for 5 cycles after en -> eng_en stays 0 until both high, then one-cycle 2'b11 pulse.
REQ-040 rst_n low during COLLECT -> all outputs at reset values immediately, rdy=1; en pulsed while rdy=0 -> no effect.
REQ-041 FOUND_ABORT_EN defined, engine 0 valid at cycle 20 -> eng_abort=2'b10 from that cycle until engine 1 eng_rdy=1.

Source files
------------

// File: rtl/multi_crack_ctrl_if.sv
// Host and engine-array signal bundle for multi_crack_ctrl.
// eng_abort exists only when FOUND_ABORT_EN is defined.
interface multi_crack_ctrl_if #(
  parameter int NUM_ENG = 2,
  parameter int KEY_W   = 24,
  parameter int CNT_W   = 32
);
  logic                     en;
  logic                     rdy;
  logic [KEY_W-1:0]         key;
  logic                     key_valid;
  logic [CNT_W-1:0]         search_cycles;
  logic [NUM_ENG-1:0]       eng_en;
  logic [NUM_ENG*KEY_W-1:0] eng_start;
  logic [KEY_W-1:0]         eng_stride;
  logic [NUM_ENG-1:0]       eng_rdy;
  logic [NUM_ENG*KEY_W-1:0] eng_key;
  logic [NUM_ENG-1:0]       eng_key_valid;
`ifdef FOUND_ABORT_EN
  logic [NUM_ENG-1:0]       eng_abort;
`endif

  modport master (
    input  en,
    input  eng_rdy,
    input  eng_key,
    input  eng_key_valid,
`ifdef FOUND_ABORT_EN
    output eng_abort,
`endif
    output rdy,
    output key,
    output key_valid,
    output search_cycles,
    output eng_en,
    output eng_start,
    output eng_stride
  );

  modport slave (
    output en,
    output eng_rdy,
    output eng_key,
    output eng_key_valid,
`ifdef FOUND_ABORT_EN
    input  eng_abort,
`endif
    input  rdy,
    input  key,
    input  key_valid,
    input  search_cycles,
    input  eng_en,
    input  eng_start,
    input  eng_stride
  );
endinterface

// File: rtl/multi_crack_ctrl.sv
// Dispatches a key search over NUM_ENG engines and collects the winner.
// Optional FOUND_ABORT_EN: abort still-running engines once a key is found.
module multi_crack_ctrl #(
  parameter int NUM_ENG = 2,
  parameter int KEY_W   = 24,
  parameter int CNT_W   = 32
) (
  input logic              clk,
  input logic              rst_n,
  multi_crack_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    COLLECT,
    REPORT
  } state_t;

  localparam logic [NUM_ENG-1:0] ALL = '1;
  localparam logic [CNT_W-1:0]   CMAX = '1;

  state_t             state, state_nxt;
  logic [NUM_ENG-1:0] done_q;
  logic [NUM_ENG-1:0] newly;
  logic [NUM_ENG-1:0] eng_en;
  logic               first_q;
  logic [KEY_W-1:0]   key_q;
  logic [KEY_W-1:0]   win_key;
  logic               key_valid_q;
  logic               win;
  logic [CNT_W-1:0]   cnt_q;

  // Lowest-index valid finisher wins; loop runs high to low so it overrides.
  always_comb begin
    newly   = '0;
    win     = 1'b0;
    win_key = '0;
    if (state == COLLECT && !first_q)
      newly = bus.eng_rdy & ~done_q;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (newly[i] && bus.eng_key_valid[i]) begin
        win     = 1'b1;
        win_key = bus.eng_key[i*KEY_W +: KEY_W];
      end
    end
    win = win && !key_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    eng_en    = '0;
    unique case (state)
      IDLE: begin
        if (bus.en)
          state_nxt = DISPATCH;
      end
      DISPATCH: begin
        if (&bus.eng_rdy) begin
          eng_en    = '1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if ((done_q | newly) == ALL)
          state_nxt = REPORT;
      end
      REPORT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q     <= 1'b0;
      done_q      <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      first_q <= (state == DISPATCH);
      if (state == IDLE && bus.en) begin
        done_q      <= '0;
        key_q       <= '0;
        key_valid_q <= 1'b0;
        cnt_q       <= '0;
      end else begin
        done_q <= done_q | newly;
        if (win) begin
          key_q       <= win_key;
          key_valid_q <= 1'b1;
        end
        if ((state == DISPATCH || state == COLLECT)
            && cnt_q != CMAX)
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef FOUND_ABORT_EN
  logic [NUM_ENG-1:0] abort_q;
  logic [NUM_ENG-1:0] abort_now;

  assign abort_now = win ? ~(done_q | newly) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      abort_q <= '0;
    else if (state_nxt != COLLECT)
      abort_q <= '0;
    else
      abort_q <= abort_q | abort_now;
  end

  assign bus.eng_abort = abort_q | abort_now;
`endif

  assign bus.rdy           = (state == IDLE);
  assign bus.key           = key_q;
  assign bus.key_valid     = key_valid_q;
  assign bus.search_cycles = cnt_q;
  assign bus.eng_en        = eng_en;
  assign bus.eng_stride    = KEY_W'(NUM_ENG);

  for (genvar g = 0; g < NUM_ENG; g++) begin : g_start
    assign bus.eng_start[g*KEY_W +: KEY_W] = KEY_W'(g);
  end

endmodule

// File: tb/tb_multi_crack_ctrl.sv
// Directed bench for multi_crack_ctrl with two modelled engines.
// Abort checks are active when FOUND_ABORT_EN is defined.
module tb_multi_crack_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  multi_crack_ctrl_if #(
    .NUM_ENG(2),
    .KEY_W(24),
    .CNT_W(32)
  ) bus ();

  multi_crack_ctrl #(
    .NUM_ENG(2),
    .KEY_W(24),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Accept en and wait out d cycles of engine 1 busy before the pulse.
  task automatic start_search(input int d);
    bus.eng_rdy = (d > 0) ? 2'b01 : 2'b11;
    bus.en = 1'b1;
    #1 chk("rdy_before_en", bus.rdy, 1);
    @(posedge clk); #1;
    bus.en = 1'b0;
    for (int c = 0; c < d; c++) begin
      #1;
      chk("eng_en_wait", bus.eng_en, 0);
      chk("rdy_dispatch", bus.rdy, 0);
      @(posedge clk); #1;
      if (c == d - 1) bus.eng_rdy = 2'b11;
    end
    #1 chk("eng_en_pulse", bus.eng_en, 2'b11);
    @(posedge clk); #1;
    chk("eng_en_single", bus.eng_en, 0);
  endtask

  // Engine i goes idle at collect cycle fi with flag vi and key ki.
  task automatic collect(input int f0, input bit v0,
                         input logic [23:0] k0,
                         input int f1, input bit v1,
                         input logic [23:0] k1);
    int fmax;
    logic [1:0] dn;
    logic [1:0] nw;
    logic [1:0] ab;
    bit won;
    fmax = (f0 > f1) ? f0 : f1;
    dn = 2'b00;
    ab = 2'b00;
    won = 1'b0;
    bus.eng_rdy = 2'b00;
    bus.eng_key_valid = 2'b00;
    for (int k = 1; k <= fmax; k++) begin
      @(posedge clk); #1;
      bus.en = (k == 2);
      nw = {k == f1, k == f0};
      if (k >= f0) begin
        bus.eng_rdy[0] = 1'b1;
        bus.eng_key[23:0] = k0;
        bus.eng_key_valid[0] = v0;
      end
      if (k >= f1) begin
        bus.eng_rdy[1] = 1'b1;
        bus.eng_key[47:24] = k1;
        bus.eng_key_valid[1] = v1;
      end
      if (!won && ((nw[0] && v0) || (nw[1] && v1))) begin
        won = 1'b1;
        ab = ~(dn | nw);
      end
      dn = dn | nw;
      #1;
`ifdef FOUND_ABORT_EN
      chk("eng_abort", bus.eng_abort, ab);
`endif
    end
    bus.en = 1'b0;
    @(posedge clk); #1;
    chk("rdy_report", bus.rdy, 0);
`ifdef FOUND_ABORT_EN
    chk("abort_report", bus.eng_abort, 0);
`endif
    @(posedge clk); #1;
    chk("rdy_after", bus.rdy, 1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    bus.en = 1'b0;
    bus.eng_rdy = 2'b11;
    bus.eng_key = '0;
    bus.eng_key_valid = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", bus.rdy, 1);
    chk("rst_key", bus.key, 0);
    chk("rst_kv", bus.key_valid, 0);
    chk("rst_cyc", bus.search_cycles, 0);
    chk("rst_en", bus.eng_en, 0);
    chk("eng_start", bus.eng_start, 48'h000001_000000);
    chk("eng_stride", bus.eng_stride, 2);
`ifdef FOUND_ABORT_EN
    chk("rst_abort", bus.eng_abort, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Engine 1 valid at 40, engine 0 invalid at 60
    start_search(0);
    collect(60, 0, 24'h0, 40, 1, 24'h000123);
    chk("t1_key", bus.key, 24'h000123);
    chk("t1_kv", bus.key_valid, 1);
    chk("t1_cyc", bus.search_cycles, 62);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("hold_rdy", bus.rdy, 1);
      chk("hold_en", bus.eng_en, 0);
      chk("hold_key", bus.key, 24'h000123);
    end

    // Later valid result is ignored
    start_search(0);
    collect(15, 1, 24'h000BBB, 10, 1, 24'h000AAA);
    chk("t2_key", bus.key, 24'h000AAA);
    chk("t2_cyc", bus.search_cycles, 17);

    // Both invalid
    start_search(0);
    collect(12, 0, 24'h000055, 8, 0, 24'h000066);
    chk("t3_key", bus.key, 0);
    chk("t3_kv", bus.key_valid, 0);
    chk("t3_cyc", bus.search_cycles, 14);

    // Same-cycle tie goes to engine 0
    start_search(0);
    collect(5, 1, 24'h000010, 5, 1, 24'h000011);
    chk("t4_key", bus.key, 24'h000010);
    chk("t4_kv", bus.key_valid, 1);
    chk("t4_cyc", bus.search_cycles, 7);

    // Engine 1 busy for 5 cycles before dispatch
    start_search(5);
    collect(3, 0, 24'h0, 3, 0, 24'h0);
    chk("t5_kv", bus.key_valid, 0);
    chk("t5_cyc", bus.search_cycles, 10);

    // Engine 0 wins early, engine 1 still running
    start_search(0);
    collect(20, 1, 24'h000ABC, 30, 0, 24'h0);
    chk("t6_key", bus.key, 24'h000ABC);
    chk("t6_cyc", bus.search_cycles, 32);

    // Reset in the middle of COLLECT
    start_search(0);
    bus.eng_rdy = 2'b00;
    bus.eng_key_valid = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k >= 2) begin
        bus.eng_rdy[0] = 1'b1;
        bus.eng_key[23:0] = 24'h000777;
        bus.eng_key_valid[0] = 1'b1;
      end
    end
    #1;
    chk("t7_key_pre", bus.key, 24'h000777);
    chk("t7_rdy_pre", bus.rdy, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rdy", bus.rdy, 1);
    chk("t7_key", bus.key, 0);
    chk("t7_kv", bus.key_valid, 0);
    chk("t7_cyc", bus.search_cycles, 0);
    chk("t7_en", bus.eng_en, 0);
`ifdef FOUND_ABORT_EN
    chk("t7_abort", bus.eng_abort, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.eng_rdy = 2'b11;
    bus.eng_key_valid = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("post_rst_en", bus.eng_en, 0);
      chk("post_rst_rdy", bus.rdy, 1);
    end

    // Recovery search after reset
    start_search(0);
    collect(2, 1, 24'h000042, 3, 0, 24'h0);
    chk("t8_key", bus.key, 24'h000042);
    chk("t8_cyc", bus.search_cycles, 5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
